// File: rtl/flag_reg_if.sv
// Bus between the flag-writing pipeline stage and the condition-code register.
// The stage supplies the instruction/result; the register returns flags and status.
interface flag_reg_if #(
  parameter int unsigned DATA_W = 16
);
  logic [3:0]        opcode;
  logic              valid;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovfl;
  logic [2:0]        F;
  logic [2:0]        F_fwd;
  logic              flags_upd;
  logic              halted;

  modport master (
    output opcode, valid, stall, flush, alu_result, alu_ovfl,
    input  F, F_fwd, flags_upd, halted
  );

  modport slave (
    input  opcode, valid, stall, flush, alu_result, alu_ovfl,
    output F, F_fwd, flags_upd, halted
  );
endinterface

// File: rtl/flag_reg.sv
// WISC condition-code register: latches {N,V,Z} per opcode, offers a same-cycle
// bypass copy, and freezes permanently on a committed HLT until reset.
module flag_reg #(
  parameter int unsigned DATA_W      = 16,
  parameter logic [2:0]  RESET_FLAGS = 3'b000
) (
  input logic        clk,
  input logic        rst_n,
  flag_reg_if.slave  bus
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpRor = 4'b0110;
  localparam logic [3:0] OpHlt = 4'b1111;

  typedef enum logic {StRun, StHalt} state_e;

  state_e     state_q, state_d;
  logic [2:0] f_q, f_d;
  logic       upd_q, upd_d;
  logic       commit;
  logic       wr_nvz;
  logic       wr_z;
  logic       z_new;

  always_comb begin
    commit  = bus.valid & ~bus.stall & ~bus.flush & (state_q == StRun);
    wr_nvz  = 1'b0;
    wr_z    = 1'b0;
    z_new   = (bus.alu_result == '0);
    f_d     = f_q;
    upd_d   = 1'b0;
    state_d = state_q;

    case (bus.opcode)
      OpAdd, OpSub:               wr_nvz = 1'b1;
      OpXor, OpSll, OpSra, OpRor: wr_z   = 1'b1;
      default:                    ;
    endcase

    // Result bits are only looked at under commit, so an undriven result on an
    // idle stage never reaches the flags.
    if (commit) begin
      if (wr_nvz) begin
        f_d = {bus.alu_result[DATA_W-1], bus.alu_ovfl, z_new};
      end else if (wr_z) begin
        f_d[0] = z_new;
      end
      upd_d = wr_nvz | wr_z;
      if (bus.opcode == OpHlt) begin
        state_d = StHalt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      f_q     <= RESET_FLAGS;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      upd_q   <= upd_d;
    end
  end

  assign bus.F         = f_q;
  assign bus.F_fwd     = f_d;
  assign bus.flags_upd = upd_q;
  assign bus.halted    = (state_q == StHalt);

endmodule

// File: tb/tb_flag_reg.sv
// Directed-vector bench for flag_reg; every expected value below is worked by hand.
module tb_flag_reg;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpHlt = 4'b1111;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  flag_reg_if #(.DATA_W(16)) bus ();

  flag_reg #(
    .DATA_W      (16),
    .RESET_FLAGS (3'b000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic v, input logic st, input logic fl,
                       input logic [15:0] res, input logic ov);
    bus.opcode     = op;
    bus.valid      = v;
    bus.stall      = st;
    bus.flush      = fl;
    bus.alu_result = res;
    bus.alu_ovfl   = ov;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] f, input logic upd,
                           input logic hlt);
    check({tag, ".F"}, {1'b0, bus.F}, {1'b0, f});
    check({tag, ".upd"}, {3'b0, bus.flags_upd}, {3'b0, upd});
    check({tag, ".halted"}, {3'b0, bus.halted}, {3'b0, hlt});
  endtask

  initial begin
    logic [3:0] nonflag_ops [6];
    nonflag_ops = '{4'b0011, 4'b0111, 4'b1000, 4'b1010, 4'b1100, 4'b1110};
    n_vec = 0;
    n_err = 0;

    rst_n = 1'b0;
    drive(OpAdd, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk_state("reset0", 3'b000, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // ADD saturating negative with overflow
    drive(OpAdd, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b1);
    check("add.fwd", {1'b0, bus.F_fwd}, 4'b0110);
    step();
    chk_state("add", 3'b110, 1'b1, 1'b0);

    // XOR only writes Z, even with ovfl asserted
    drive(OpXor, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    check("xor.fwd", {1'b0, bus.F_fwd}, 4'b0111);
    step();
    chk_state("xor", 3'b111, 1'b1, 1'b0);

    // Idle cycle with X result: nothing moves, pulse drops
    drive(OpAdd, 1'b0, 1'b0, 1'b0, 16'hxxxx, 1'b0);
    check("idle.fwd", {1'b0, bus.F_fwd}, 4'b0111);
    step();
    chk_state("idle", 3'b111, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 3'b000, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // Stall / flush suppress commit
    drive(OpSub, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    check("stall.fwd", {1'b0, bus.F_fwd}, 4'b0000);
    step();
    chk_state("stall", 3'b000, 1'b0, 1'b0);
    drive(OpSub, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0);
    step();
    chk_state("flush", 3'b000, 1'b0, 1'b0);
    drive(OpSub, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    chk_state("release", 3'b001, 1'b1, 1'b0);

    // Positive saturation: Z evaluated on saturated value
    drive(OpAdd, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    step();
    chk_state("sat", 3'b010, 1'b1, 1'b0);

    // valid=0 with ADD opcode
    drive(OpAdd, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    chk_state("novalid", 3'b010, 1'b0, 1'b0);

    // Non-flag opcodes
    foreach (nonflag_ops[i]) begin
      drive(nonflag_ops[i], 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      step();
      chk_state($sformatf("nonflag%0d", i), 3'b010, 1'b0, 1'b0);
    end

    // Shift: Z cleared, N/V held despite result MSB and ovfl
    drive(OpAdd, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    chk_state("add0", 3'b001, 1'b1, 1'b0);
    drive(OpSll, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b1);
    step();
    chk_state("sll", 3'b000, 1'b1, 1'b0);

    // Back-to-back commits
    drive(OpAdd, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0);
    step();
    chk_state("b2b0", 3'b100, 1'b1, 1'b0);
    drive(OpSub, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    chk_state("b2b1", 3'b001, 1'b1, 1'b0);

    // Stalled and flushed HLT do not halt
    drive(OpHlt, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    step();
    chk_state("hlt_stall", 3'b001, 1'b0, 1'b0);
    drive(OpHlt, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
    step();
    chk_state("hlt_flush", 3'b001, 1'b0, 1'b0);

    // Committed HLT, then everything ignored
    drive(OpHlt, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    chk_state("hlt", 3'b001, 1'b0, 1'b1);
    drive(OpAdd, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b1);
    check("halt.fwd", {1'b0, bus.F_fwd}, 4'b0001);
    step();
    chk_state("halt_add", 3'b001, 1'b0, 1'b1);
    step();
    chk_state("halt_add2", 3'b001, 1'b0, 1'b1);

    // Reset leaves HALT; next ADD updates
    rst_n = 1'b0;
    #1;
    chk_state("halt_rst", 3'b000, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    drive(OpAdd, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0);
    step();
    chk_state("post_rst", 3'b100, 1'b1, 1'b0);
    drive(OpAdd, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    chk_state("post_idle", 3'b100, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
